// File: rtl/counter_ctrl_unit.sv
// Run/stop/clear/mode control and 0..MAX_COUNT-1 count register for the UART-driven counter.
// Optional UART command decode is compiled in when UART_CMD_EN is defined.
module counter_ctrl_unit #(
    parameter int MAX_COUNT = 10000,
    parameter int CW        = $clog2(MAX_COUNT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_btn_run_stop,
    input  logic          i_btn_clear,
    input  logic          i_btn_mode,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_done,
    input  logic          i_tick,
    output logic          o_tick_enable,
    output logic          o_tick_clear,
    output logic [CW-1:0] o_count,
    output logic          o_down,
    output logic          o_running,
    output logic          o_wrap
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [CW-1:0] MAX_VAL = CW'(MAX_COUNT - 1);

    state_t        state;
    state_t        state_nx;
    logic          cmd_clear;
    logic          cmd_toggle;
    logic          cmd_run;
    logic          cmd_stop;
    logic          cmd_mode;
    logic          btn_any;
    logic [CW-1:0] count_nx;
    logic          down_nx;
    logic          wrap_nx;

    assign btn_any = i_btn_run_stop | i_btn_clear | i_btn_mode;

`ifdef UART_CMD_EN
    logic uart_clear;
    logic uart_run;
    logic uart_stop;
    logic uart_mode;

    always_comb begin
        uart_clear = i_rx_done && (i_rx_data == 8'h43);
        uart_run   = i_rx_done && (i_rx_data == 8'h52);
        uart_stop  = i_rx_done && (i_rx_data == 8'h53);
        uart_mode  = i_rx_done && (i_rx_data == 8'h4D);
    end

    // Any button activity masks the UART source for that cycle.
    always_comb begin
        if (btn_any) begin
            cmd_clear  = i_btn_clear;
            cmd_toggle = !i_btn_clear && i_btn_run_stop;
            cmd_mode   = !i_btn_clear && !i_btn_run_stop && i_btn_mode;
            cmd_run    = 1'b0;
            cmd_stop   = 1'b0;
        end else begin
            cmd_clear  = uart_clear;
            cmd_toggle = 1'b0;
            cmd_mode   = uart_mode;
            cmd_run    = uart_run;
            cmd_stop   = uart_stop;
        end
    end
`else
    logic unused_rx;
    assign unused_rx = ^{i_rx_data, i_rx_done, btn_any};

    always_comb begin
        cmd_clear  = i_btn_clear;
        cmd_toggle = !i_btn_clear && i_btn_run_stop;
        cmd_mode   = !i_btn_clear && !i_btn_run_stop && i_btn_mode;
        cmd_run    = 1'b0;
        cmd_stop   = 1'b0;
    end
`endif

    // CLEAR lasts one cycle and ignores every state command while in it.
    always_comb begin
        state_nx = state;
        case (state)
            ST_STOP: begin
                if (cmd_clear)                 state_nx = ST_CLEAR;
                else if (cmd_toggle || cmd_run) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (cmd_clear)                  state_nx = ST_CLEAR;
                else if (cmd_toggle || cmd_stop) state_nx = ST_STOP;
            end
            ST_CLEAR: state_nx = ST_STOP;
            default:  state_nx = ST_STOP;
        endcase
    end

    // The tick uses the direction held before any same-cycle mode toggle.
    always_comb begin
        count_nx = o_count;
        wrap_nx  = 1'b0;
        down_nx  = o_down ^ cmd_mode;
        if (state == ST_CLEAR || cmd_clear) begin
            count_nx = '0;
        end else if (state == ST_RUN && i_tick) begin
            if (!o_down) begin
                if (o_count == MAX_VAL) begin
                    count_nx = '0;
                    wrap_nx  = 1'b1;
                end else begin
                    count_nx = o_count + CW'(1);
                end
            end else begin
                if (o_count == '0) begin
                    count_nx = MAX_VAL;
                    wrap_nx  = 1'b1;
                end else begin
                    count_nx = o_count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_STOP;
            o_count       <= '0;
            o_down        <= 1'b0;
            o_wrap        <= 1'b0;
            o_running     <= 1'b0;
            o_tick_enable <= 1'b0;
            o_tick_clear  <= 1'b0;
        end else begin
            state         <= state_nx;
            o_count       <= count_nx;
            o_down        <= down_nx;
            o_wrap        <= wrap_nx;
            o_running     <= (state_nx == ST_RUN);
            o_tick_enable <= (state_nx == ST_RUN);
            o_tick_clear  <= (state_nx == ST_CLEAR);
        end
    end

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// Bench for counter_ctrl_unit: directed scenarios plus random stimulus against a
// cycle-level behavioural model; follows UART_CMD_EN the same way as the design.
module tb_counter_ctrl_unit;

    localparam int MAX_COUNT = 10000;
    localparam int CW        = $clog2(MAX_COUNT);

`ifdef UART_CMD_EN
    localparam bit UART_EN = 1'b1;
`else
    localparam bit UART_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_btn_run_stop = 1'b0;
    logic          i_btn_clear = 1'b0;
    logic          i_btn_mode = 1'b0;
    logic [7:0]    i_rx_data = 8'h00;
    logic          i_rx_done = 1'b0;
    logic          i_tick = 1'b0;
    logic          o_tick_enable;
    logic          o_tick_clear;
    logic [CW-1:0] o_count;
    logic          o_down;
    logic          o_running;
    logic          o_wrap;

    int n_cmp = 0;
    int n_err = 0;

    // model: m_st 0=STOP 1=RUN 2=CLEAR
    int m_st   = 0;
    int m_cnt  = 0;
    int m_down = 0;
    int m_wrap = 0;

    counter_ctrl_unit #(.MAX_COUNT(MAX_COUNT)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_btn_run_stop (i_btn_run_stop),
        .i_btn_clear    (i_btn_clear),
        .i_btn_mode     (i_btn_mode),
        .i_rx_data      (i_rx_data),
        .i_rx_done      (i_rx_done),
        .i_tick         (i_tick),
        .o_tick_enable  (o_tick_enable),
        .o_tick_clear   (o_tick_clear),
        .o_count        (o_count),
        .o_down         (o_down),
        .o_running      (o_running),
        .o_wrap         (o_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the specification's rules, written over plain integers.
    task automatic model_step(input bit r, input bit rs, input bit clr, input bit md,
                              input bit rxd, input logic [7:0] rxb, input bit tk);
        bit c_clr, c_tog, c_run, c_stop, c_mode;
        c_clr = 0; c_tog = 0; c_run = 0; c_stop = 0; c_mode = 0;
        if (!r) begin
            m_st = 0; m_cnt = 0; m_down = 0; m_wrap = 0;
            return;
        end
        if (rs || clr || md) begin
            if (clr)     c_clr = 1;
            else if (rs) c_tog = 1;
            else         c_mode = 1;
        end else if (UART_EN && rxd) begin
            c_clr  = (rxb == 8'h43);
            c_run  = (rxb == 8'h52);
            c_stop = (rxb == 8'h53);
            c_mode = (rxb == 8'h4D);
        end
        m_wrap = 0;
        if (m_st == 2) begin
            m_st = 0;
        end else if (c_clr) begin
            m_st = 2; m_cnt = 0;
        end else begin
            if (m_st == 1 && tk) begin
                if (m_down == 0) begin
                    m_wrap = (m_cnt == MAX_COUNT - 1);
                    m_cnt  = (m_cnt + 1) % MAX_COUNT;
                end else begin
                    m_wrap = (m_cnt == 0);
                    m_cnt  = (m_cnt + MAX_COUNT - 1) % MAX_COUNT;
                end
            end
            if (c_tog)                    m_st = 1 - m_st;
            else if (c_run && m_st == 0)  m_st = 1;
            else if (c_stop && m_st == 1) m_st = 0;
        end
        if (c_mode) m_down = 1 - m_down;
    endtask

    task automatic step(input bit r, input bit rs, input bit clr, input bit md,
                        input bit rxd, input logic [7:0] rxb, input bit tk);
        rst = r; i_btn_run_stop = rs; i_btn_clear = clr; i_btn_mode = md;
        i_rx_done = rxd; i_rx_data = rxb; i_tick = tk;
        model_step(r, rs, clr, md, rxd, rxb, tk);
        @(posedge clk);
        #1;
        check("count",   int'(o_count),   m_cnt);
        check("down",    int'(o_down),    m_down);
        check("wrap",    int'(o_wrap),    m_wrap);
        check("running", int'(o_running), int'(m_st == 1));
        check("tick_en", int'(o_tick_enable), int'(m_st == 1));
        check("tick_clr", int'(o_tick_clear), int'(m_st == 2));
        rst = 1'b1; i_btn_run_stop = 0; i_btn_clear = 0; i_btn_mode = 0;
        i_rx_done = 0; i_tick = 0;
    endtask

    task automatic idle();           step(1, 0, 0, 0, 0, 8'h00, 0); endtask
    task automatic press_rs();       step(1, 1, 0, 0, 0, 8'h00, 0); endtask
    task automatic press_clr();      step(1, 0, 1, 0, 0, 8'h00, 0); endtask
    task automatic press_mode();     step(1, 0, 0, 1, 0, 8'h00, 0); endtask
    task automatic uart(input logic [7:0] b); step(1, 0, 0, 0, 1, b, 0); endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 8'h00, 1);
    endtask

    initial begin
        logic [7:0] bytes [5];
        bytes = '{8'h52, 8'h53, 8'h43, 8'h4D, 8'h41};

        // reset and first run
        step(0, 0, 0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 0, 0, 8'h00, 0);
        check("rst_count", int'(o_count), 0);
        check("rst_running", int'(o_running), 0);
        press_rs();
        check("run_en", int'(o_tick_enable), 1);

        // up wrap at MAX_COUNT-1
        ticks(MAX_COUNT - 1);
        check("at_max", int'(o_count), MAX_COUNT - 1);
        ticks(1);
        check("up_wrap_cnt", int'(o_count), 0);
        check("up_wrap", int'(o_wrap), 1);
        idle();
        check("wrap_one_cycle", int'(o_wrap), 0);

        // down wrap from 0
        press_clr();
        check("clr_pulse", int'(o_tick_clear), 1);
        idle();
        check("clr_done", int'(o_tick_clear), 0);
        press_mode();
        press_rs();
        ticks(1);
        check("down_wrap_cnt", int'(o_count), MAX_COUNT - 1);
        check("down_wrap", int'(o_wrap), 1);

        // UART commands, or no effect without the decode
        press_rs();
        uart(8'h52);
        check("uart_R", int'(o_running), int'(UART_EN));
        uart(8'h53);
        check("uart_S", int'(o_running), 0);
        uart(8'h43);
        check("uart_C", int'(o_tick_clear), int'(UART_EN));
        idle();
        uart(8'h41);
        check("uart_A", int'(o_running), 0);
        uart(8'h4D);

        // button beats UART in the same cycle
        step(1, 1, 0, 0, 1, 8'h43, 0);
        check("arb_run", int'(o_running), 1);
        check("arb_noclr", int'(o_tick_clear), 0);

        // tick together with clear at count 57
        press_clr();
        idle();
        if (o_down) press_mode();
        press_rs();
        ticks(57);
        check("cnt57", int'(o_count), 57);
        step(1, 0, 1, 0, 0, 8'h00, 1);
        check("tc_count", int'(o_count), 0);
        check("tc_wrap", int'(o_wrap), 0);
        idle();
        check("tc_stop", int'(o_running), 0);

        // tick with stop, tick with mode toggle
        press_rs();
        ticks(3);
        step(1, 1, 0, 0, 0, 8'h00, 1);
        check("tick_stop", int'(o_count), 4);
        press_rs();
        step(1, 0, 0, 1, 0, 8'h00, 1);
        check("tick_mode", int'(o_count), 5);
        ticks(2);
        check("after_mode", int'(o_count), 3);

        // reset mid-run
        ticks(5);
        step(0, 0, 0, 0, 0, 8'h00, 1);
        check("midrst_wrap", int'(o_wrap), 0);
        check("midrst_run", int'(o_running), 0);

        // random
        for (int i = 0; i < 4000; i++) begin
            bit r, rs, clr, md, rxd, tk;
            logic [7:0] b;
            r   = ($urandom_range(0, 299) != 0);
            rs  = ($urandom_range(0, 11) == 0);
            clr = ($urandom_range(0, 29) == 0);
            md  = ($urandom_range(0, 15) == 0);
            rxd = ($urandom_range(0, 3) == 0);
            b   = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                              : bytes[$urandom_range(0, 4)];
            tk  = ($urandom_range(0, 1) == 0);
            step(r, rs, clr, md, rxd, b, tk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
